// File: rtl/texture_block_fetch_if.sv
// Request, memory-arbiter and decoder-side signals of texture_block_fetch.
// slave is the fetch block's view; master is the requester/memory/decoder side.
interface texture_block_fetch_if #(
    parameter int ADDR_W = 24,
    parameter int UV_W   = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [UV_W-1:0]   req_u;
    logic [UV_W-1:0]   req_v;
    logic [ADDR_W-1:0] tex_base;
    logic [3:0]        tex_width_log2;
    logic              inval;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [15:0]       mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      block_data;
    logic [3:0]        texel_idx;
    logic              miss_pulse;

    modport slave (
        input  req_valid, req_u, req_v, tex_base, tex_width_log2, inval,
               mem_ack, mem_rvalid, mem_rdata, out_ready,
        output req_ready, mem_req, mem_addr, out_valid, block_data, texel_idx, miss_pulse
    );

    modport master (
        output req_valid, req_u, req_v, tex_base, tex_width_log2, inval,
               mem_ack, mem_rvalid, mem_rdata, out_ready,
        input  req_ready, mem_req, mem_addr, out_valid, block_data, texel_idx, miss_pulse
    );
endinterface

// File: rtl/texture_block_fetch.sv
// Texel request -> 4x4 BC3 block fetch (8 x 16-bit burst) with a one-entry block tag.
// Latency: hit 1 cycle after accept; miss mem_req next cycle, out_valid after 8th word.
// Backpressure: out_valid held until out_ready; req_ready only in IDLE, one burst at a time.
module texture_block_fetch #(
    parameter int ADDR_W = 24,
    parameter int UV_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    texture_block_fetch_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, FILL, OUT} state_t;

    localparam logic [3:0] W_MAX = 4'(UV_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              tag_valid_q, tag_valid_d;
    logic              inval_seen_q, inval_seen_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [127:0]      block_data_q, block_data_d;
    logic [3:0]        texel_idx_q, texel_idx_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic              mem_req_q, mem_req_d;
    logic              out_valid_q, out_valid_d;
    logic              req_ready_q, req_ready_d;

    logic [3:0]        w_eff, sh;
    logic [UV_W-1:0]   bx, by;
    logic [ADDR_W-1:0] blk_off, blk_addr;
    logic              hit;

    // Block address: row of blocks is (width/4) wide, each block is 8 words.
    always_comb begin
        if (bus.tex_width_log2 < 4'd2) begin
            w_eff = 4'd2;
        end else if (bus.tex_width_log2 > W_MAX) begin
            w_eff = W_MAX;
        end else begin
            w_eff = bus.tex_width_log2;
        end
        sh       = w_eff - 4'd2;
        bx       = (bus.req_u >> 2) & ~({UV_W{1'b1}} << sh);
        by       = bus.req_v >> 2;
        blk_off  = ((ADDR_W'(by) << sh) | ADDR_W'(bx)) << 3;
        blk_addr = bus.tex_base + blk_off;
        // An inval in the accept cycle wins over the stored tag.
        hit      = tag_valid_q && !bus.inval && (tag_q == blk_addr);
    end

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        tag_d        = tag_q;
        tag_valid_d  = tag_valid_q;
        inval_seen_d = inval_seen_q;
        cnt_d        = cnt_q;
        block_data_d = block_data_q;
        texel_idx_d  = texel_idx_q;
        miss_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.inval) tag_valid_d = 1'b0;
                if (bus.req_valid) begin
                    texel_idx_d  = {bus.req_v[1:0], bus.req_u[1:0]};
                    mem_addr_d   = blk_addr;
                    inval_seen_d = 1'b0;
                    if (hit) begin
                        state_d = OUT;
                    end else begin
                        state_d      = REQ;
                        tag_valid_d  = 1'b0;
                        miss_pulse_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.inval) inval_seen_d = 1'b1;
                if (bus.mem_ack) begin
                    state_d = FILL;
                    cnt_d   = 3'd0;
                end
            end
            FILL: begin
                if (bus.inval) inval_seen_d = 1'b1;
                if (bus.mem_rvalid) begin
                    block_data_d[{cnt_q, 4'b0000} +: 16] = bus.mem_rdata;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d     = OUT;
                        tag_d       = mem_addr_q;
                        tag_valid_d = !(inval_seen_q || bus.inval);
                    end
                end
            end
            OUT: begin
                if (bus.inval) tag_valid_d = 1'b0;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mem_req_d   = (state_d == REQ);
        out_valid_d = (state_d == OUT);
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            inval_seen_q <= 1'b0;
            cnt_q        <= 3'd0;
            block_data_q <= '0;
            texel_idx_q  <= 4'd0;
            miss_pulse_q <= 1'b0;
            mem_req_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            tag_q        <= tag_d;
            tag_valid_q  <= tag_valid_d;
            inval_seen_q <= inval_seen_d;
            cnt_q        <= cnt_d;
            block_data_q <= block_data_d;
            texel_idx_q  <= texel_idx_d;
            miss_pulse_q <= miss_pulse_d;
            mem_req_q    <= mem_req_d;
            out_valid_q  <= out_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.block_data = block_data_q;
    assign bus.texel_idx  = texel_idx_q;
    assign bus.miss_pulse = miss_pulse_q;
endmodule

// File: tb/tb_texture_block_fetch.sv
// Directed bench for texture_block_fetch: miss/hit paths, stalls, inval, reset abort.
module tb_texture_block_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    texture_block_fetch_if #(.ADDR_W(24), .UV_W(10)) bus ();

    texture_block_fetch #(.ADDR_W(24), .UV_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] blk(input logic [15:0] first, input logic [15:0] step);
        logic [127:0] b;
        for (int k = 0; k < 8; k++) b[16*k +: 16] = first + 16'(k) * step;
        return b;
    endfunction

    task automatic issue(input logic [9:0] u, input logic [9:0] v,
                         input logic [23:0] base, input logic [3:0] w);
        bus.req_valid      = 1'b1;
        bus.req_u          = u;
        bus.req_v          = v;
        bus.tex_base       = base;
        bus.tex_width_log2 = w;
        tick();
        bus.req_valid = 1'b0;
        bus.inval     = 1'b0;
    endtask

    task automatic fill(input logic [15:0] first, input logic [15:0] step,
                        input int inval_at, input bit gaps);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = first + 16'(k) * step;
            bus.inval      = (k == inval_at);
            tick();
            bus.mem_rvalid = 1'b0;
            bus.inval      = 1'b0;
            if (gaps && k != 7) tick();
        end
    endtask

    task automatic consume;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("consume_out_valid", 128'(bus.out_valid), 128'd0);
        chk("consume_req_ready", 128'(bus.req_ready), 128'd1);
    endtask

    initial begin
        bus.req_valid = 0; bus.req_u = 0; bus.req_v = 0; bus.tex_base = 0;
        bus.tex_width_log2 = 0; bus.inval = 0; bus.mem_ack = 0;
        bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.out_ready = 0;

        tick(); tick();
        chk("rst_req_ready", 128'(bus.req_ready), 128'd1);
        chk("rst_mem_req", 128'(bus.mem_req), 128'd0);
        chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_block_data", bus.block_data, 128'd0);
        chk("rst_texel_idx", 128'(bus.texel_idx), 128'd0);
        chk("rst_miss_pulse", 128'(bus.miss_pulse), 128'd0);
        rst = 1'b0;

        // First miss: u=5 v=6, 16-texel-wide texture.
        issue(10'd5, 10'd6, 24'h001000, 4'd4);
        chk("miss1_mem_req", 128'(bus.mem_req), 128'd1);
        chk("miss1_mem_addr", 128'(bus.mem_addr), 128'h001028);
        chk("miss1_pulse", 128'(bus.miss_pulse), 128'd1);
        chk("miss1_req_ready", 128'(bus.req_ready), 128'd0);
        tick();
        chk("miss1_pulse_once", 128'(bus.miss_pulse), 128'd0);
        chk("miss1_req_held", 128'(bus.mem_req), 128'd1);
        fill(16'h1111, 16'h1111, -1, 1'b0);
        chk("miss1_out_valid", 128'(bus.out_valid), 128'd1);
        chk("miss1_block", bus.block_data, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
        chk("miss1_idx", 128'(bus.texel_idx), 128'h9);
        consume();

        // Hit in the same block, then 5 stalled cycles in OUT.
        issue(10'd6, 10'd5, 24'h001000, 4'd4);
        chk("hit_out_valid", 128'(bus.out_valid), 128'd1);
        chk("hit_mem_req", 128'(bus.mem_req), 128'd0);
        chk("hit_miss_pulse", 128'(bus.miss_pulse), 128'd0);
        chk("hit_idx", 128'(bus.texel_idx), 128'h6);
        chk("hit_block", bus.block_data, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_out_valid", 128'(bus.out_valid), 128'd1);
            chk("stall_req_ready", 128'(bus.req_ready), 128'd0);
            chk("stall_idx", 128'(bus.texel_idx), 128'h6);
            chk("stall_block", bus.block_data, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
        end
        consume();

        // Back-to-back hits with out_ready held high: 2-cycle throughput.
        bus.out_ready = 1'b1;
        issue(10'd4, 10'd4, 24'h001000, 4'd4);
        chk("b2b_out1", 128'(bus.out_valid), 128'd1);
        chk("b2b_idx1", 128'(bus.texel_idx), 128'h0);
        tick();
        chk("b2b_ready", 128'(bus.req_ready), 128'd1);
        issue(10'd7, 10'd7, 24'h001000, 4'd4);
        chk("b2b_out2", 128'(bus.out_valid), 128'd1);
        chk("b2b_idx2", 128'(bus.texel_idx), 128'hF);
        tick();
        bus.out_ready = 1'b0;
        chk("b2b_idle", 128'(bus.req_ready), 128'd1);

        // inval during FILL word 3: data intact, tag not kept.
        issue(10'd0, 10'd0, 24'h001000, 4'd4);
        chk("inv_miss_addr", 128'(bus.mem_addr), 128'h001000);
        fill(16'hA000, 16'h0001, 3, 1'b0);
        chk("inv_block", bus.block_data, blk(16'hA000, 16'h0001));
        consume();
        issue(10'd0, 10'd0, 24'h001000, 4'd4);
        chk("inv_refetch_pulse", 128'(bus.miss_pulse), 128'd1);
        chk("inv_refetch_req", 128'(bus.mem_req), 128'd1);
        fill(16'hB000, 16'h0001, -1, 1'b0);
        chk("inv_refetch_block", bus.block_data, blk(16'hB000, 16'h0001));
        consume();

        // Late ack with spurious rvalid in REQ, gapped words in FILL.
        issue(10'd8, 10'd0, 24'h001000, 4'd4);
        for (int i = 0; i < 10; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 16'hDEAD;
            tick();
            chk("late_addr", 128'(bus.mem_addr), 128'h001010);
            chk("late_req", 128'(bus.mem_req), 128'd1);
        end
        bus.mem_rvalid = 1'b0;
        fill(16'hC000, 16'h0011, -1, 1'b1);
        chk("late_block", bus.block_data, blk(16'hC000, 16'h0011));
        consume();

        // Width clamped to UV_W, address wraps; reset at FILL word 4.
        issue(10'h3FF, 10'd4, 24'hFFFF00, 4'd15);
        chk("wide_addr", 128'(bus.mem_addr), 128'h000EF8);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 16'h5500 + 16'(k);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstfill_mem_req", 128'(bus.mem_req), 128'd0);
        chk("rstfill_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rstfill_req_ready", 128'(bus.req_ready), 128'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstfill_late_out", 128'(bus.out_valid), 128'd0);
            chk("rstfill_late_req", 128'(bus.mem_req), 128'd0);
        end
        bus.mem_rvalid = 1'b0;
        issue(10'h3FF, 10'd4, 24'hFFFF00, 4'd15);
        chk("rstfill_remiss", 128'(bus.miss_pulse), 128'd1);
        chk("rstfill_addr", 128'(bus.mem_addr), 128'h000EF8);
        fill(16'hE000, 16'h0002, -1, 1'b0);
        chk("wide_block", bus.block_data, blk(16'hE000, 16'h0002));
        chk("wide_idx", 128'(bus.texel_idx), 128'h3);
        consume();

        // Width clamped up to 4: bx masked away.
        issue(10'd7, 10'd9, 24'h001000, 4'd0);
        chk("narrow_pulse", 128'(bus.miss_pulse), 128'd1);
        chk("narrow_addr", 128'(bus.mem_addr), 128'h001010);
        fill(16'hF000, 16'h0003, -1, 1'b0);
        consume();
        issue(10'd7, 10'd9, 24'h001000, 4'd0);
        chk("narrow_hit", 128'(bus.out_valid), 128'd1);
        chk("narrow_hit_block", bus.block_data, blk(16'hF000, 16'h0003));
        consume();

        // inval while idle, then inval in the same cycle as the request.
        bus.inval = 1'b1;
        tick();
        bus.inval = 1'b0;
        issue(10'd7, 10'd9, 24'h001000, 4'd0);
        chk("idle_inval_miss", 128'(bus.miss_pulse), 128'd1);
        fill(16'h1000, 16'h0001, -1, 1'b0);
        consume();
        bus.inval = 1'b1;
        issue(10'd7, 10'd9, 24'h001000, 4'd0);
        chk("same_cycle_inval_miss", 128'(bus.miss_pulse), 128'd1);
        fill(16'h2000, 16'h0001, -1, 1'b0);
        chk("same_cycle_block", bus.block_data, blk(16'h2000, 16'h0001));
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/texture_block_fetch.md
# texture_block_fetch

Upstream feeder for the BC3 texture decoder in the pixel pipeline. Accepts one texel request (u, v), computes the 4x4 block word address, fetches the 16-byte block as eight 16-bit words over the memory-arbiter port, and presents a 128-bit `block_data` plus a 4-bit `texel_idx` to the decoder. Holds a single-entry block tag so consecutive texels in the same block skip the refetch.

## Interface
- ADDR_W, 24, memory word-address width (one word = 16 bits)
- UV_W, 10, texel coordinate width
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  texel request valid
- req_ready  out  1  block can accept a request
- req_u  in  UV_W  texel x coordinate
- req_v  in  UV_W  texel y coordinate
- tex_base  in  ADDR_W  texture base word address; sampled on request acceptance
- tex_width_log2  in  4  log2 texture width; values below 2 treated as 2, values above UV_W treated as UV_W
- inval  in  1  one-cycle pulse; invalidates the cached block tag
- mem_req  out  1  burst read request
- mem_addr  out  ADDR_W  burst start word address
- mem_ack  in  1  arbiter accepts the burst (one cycle)
- mem_rvalid  in  1  read word valid
- mem_rdata  in  16  read word
- out_valid  out  1  block_data/texel_idx valid
- out_ready  in  1  decoder consumes output
- block_data  out  128  assembled block, little-endian
- texel_idx  out  4  texel within block, {v[1:0], u[1:0]}
- miss_pulse  out  1  one-cycle pulse per burst issued

## Operation
- States: IDLE, REQ, FILL, OUT.
- IDLE: req_ready=1. On req_valid: register texel_idx={req_v[1:0],req_u[1:0]}; compute bx=u>>2 (masked to width bits), by=v>>2, blk_addr = tex_base + (((by << (w-2)) | bx) << 3), modulo 2^ADDR_W. If tag_valid and tag==blk_addr -> OUT (hit, block_data unchanged). Else -> REQ; tag_valid cleared.
- REQ: mem_req=1, mem_addr=blk_addr held stable until mem_ack; miss_pulse high on the first REQ cycle only. On mem_ack -> FILL, word counter=0.
- FILL: each mem_rvalid writes mem_rdata to block_data[16k+15:16k], k increments. On 8th word (k=7) -> OUT; tag=blk_addr, tag_valid=1 unless an inval was seen during REQ/FILL.
- OUT: out_valid=1; block_data, texel_idx stable. On out_ready -> IDLE.
- inval: in IDLE/OUT clears tag_valid immediately; in REQ/FILL sets a sticky flag that suppresses the tag_valid set at fill end (data still delivered). inval simultaneous with an accepted request in IDLE: lookup treats tag as invalid (miss).
- mem_rvalid outside FILL is ignored. mem_ack outside REQ ignored.
- Only one outstanding burst; no request accepted outside IDLE.

## Timing
- Reset values: state=IDLE, req_ready=1 (in IDLE after reset), mem_req=0, mem_addr=0, out_valid=0, block_data=0, texel_idx=0, miss_pulse=0, tag_valid=0, word counter=0.
- Reset mid-REQ/FILL: aborts, next cycle IDLE; late rvalid words dropped.
- Hit latency: request accepted cycle N -> out_valid at N+1.
- Miss: mem_req at N+1; mem_ack at cycle A; out_valid the cycle after the 8th mem_rvalid.
- Back-to-back hits: accept N, out N+1, consumed N+1 (out_ready=1), next accept N+2 (2-cycle throughput).
- All outputs registered; no combinational path from inputs to mem_req or out_valid.

## Test plan
- Reset then request u=5,v=6, base=0x001000, w_log2=4: mem_addr=0x001000+((1<<2)|1)<<3=0x001028, miss_pulse once; feed words 0x1111..0x8888 -> block_data[15:0]=0x1111, [127:112]=0x8888, texel_idx=0x9.
- Follow with u=6,v=5 same texture: no mem_req, out_valid one cycle after accept, texel_idx=0x6, block_data unchanged.
- Hold out_ready=0 for 5 cycles in OUT: out_valid, block_data, texel_idx stable, req_ready=0; release -> IDLE next cycle.
- Pulse inval during FILL word 3: block delivered intact; repeating the same request refetches (miss_pulse again).
- Delay mem_ack 10 cycles with rvalid spurious in REQ: mem_addr stable, spurious words ignored, block correct.
- Assert rst at FILL word 4: next cycle mem_req=0, out_valid=0, req_ready=1; remaining 4 rvalid words ignored; same request afterwards misses.
